fp_mul_pipe: RTL and testbench
==============================

Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier.
- Successor to the combinational single-precision multiplier used in the Maxnet datapath.
- Adds configurable exponent/mantissa widths, selectable rounding, special-value handling, overflow/underflow flags and a valid/ready handshake with backpressure.
- Sits between the weight/activation operand buffers and the accumulator stage.

Parameters:
- EXP_W, 8, exponent field width. BIAS is derived as 2^(EXP_W-1)-1.
- MAN_W, 23, stored mantissa width; the hidden 1 is implicit.
- ROUND_MODE, 1, rounding mode: 0 = truncate, 1 = round-to-nearest-even.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands a/b valid
- in_ready  out  1  block accepts operands this cycle
- a  in  1+EXP_W+MAN_W  operand A {sign, exp, man}
- b  in  1+EXP_W+MAN_W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out  out  1+EXP_W+MAN_W  product
- ovf  out  1  result saturated to infinity by exponent overflow; qualified by out_valid
- unf  out  1  result flushed to zero by exponent underflow; qualified by out_valid

Behaviour:
- Reset (rst=1 at a clk edge): all stage valids = 0, out_valid = 0, out = 0, ovf = 0, unf = 0. Any in-flight operations are discarded. in_ready = 1 in the cycle after reset.
- Pipeline:
  - 3 register stages, S1 -> S2 -> S3. S3 drives the outputs. Latency = 3 cycles from acceptance to out_valid with no stall.
  - Global advance enable: adv = ~S3.valid | out_ready. in_ready = adv (combinational).
  - Input is accepted when in_valid & in_ready.
  - When adv = 0, all stages hold their contents and valid bits unchanged.
  - Bubbles are not squeezed; one result per cycle at full throughput.
- S1 (decode / classify):
  - Latch sign = a.s ^ b.s.
  - Classify each operand:
    - zero: exp = 0; denormals are flushed to zero.
    - inf: exp all-ones, man = 0.
    - nan: exp all-ones, man != 0.
    - normal: everything else.
  - Exponent sum e = a.exp + b.exp - BIAS, computed signed, EXP_W+2 bits wide.
- S2 (multiply): P = {1, a.man} * {1, b.man}, unsigned, 2*MAN_W+2 bits.
- S3 (normalise / round / pack):
  - If P MSB = 1: shift right by 1 and increment e.
  - Keep MAN_W bits below the leading 1. Guard = next bit; sticky = OR of the remaining bits.
  - ROUND_MODE = 1: increment the mantissa if guard & (sticky | lsb). A mantissa carry-out sets the mantissa to 0 and increments e.
  - ROUND_MODE = 0: discard guard and sticky.
  - If e >= 2^EXP_W - 1: out = {sign, all-ones, 0}, ovf = 1.
  - If e <= 0: out = +0 (all zeros), unf = 1.
- Special-value precedence, highest first:
  1. Any NaN, or inf*zero: out = canonical NaN {0, all-ones, 1 followed by zeros}, ovf = unf = 0.
  2. Any inf: out = {sign, all-ones, 0}, ovf = 0.
  3. Any zero: out = +0 (sign forced 0), unf = 0.
  4. Otherwise: normal path as above.
- Zero results from zero operands are always +0, preserving the existing datapath convention.
- ovf/unf are registered with out in S3, held while stalled, and cleared when S3 empties.
- Simultaneous events: if S3 is consumed and a new input is accepted in the same cycle, all stages advance together with no loss.
- out and flags are don't-care-stable while out_valid = 0. The bench checks them only when out_valid = 1.

Test Plan:
- EXP_W=8, MAN_W=23, RNE, out_ready=1:
  - a=0x40000000 (2.0), b=0x40400000 (3.0) -> out=0x40C00000 exactly 3 cycles later, ovf=unf=0.
  - a=0x3FC00000, b=0x3FC00000 -> 0x40100000 (2.25); exercises the normalisation shift.
- Rounding tie: a=0x3F800001, b=0x3FC00000 -> RNE out=0x3FC00002; ROUND_MODE=0 out=0x3FC00001.
- Special values:
  - a=0x7F000000, b=0x7F000000 -> 0x7F800000, ovf=1.
  - a=0x00800000, b=0x00800000 -> 0x00000000, unf=1.
  - a=0x7F800000, b=0x00000000 -> 0x7FC00000.
  - a=0x80000000, b=0x40000000 -> 0x00000000.
- Backpressure: stream 8 back-to-back operand pairs, hold out_ready=0 for 5 cycles mid-stream -> in_ready drops once S3 is full; all 8 results arrive in order, none lost or duplicated; out held stable while stalled.
- Reset mid-operation: assert rst with 3 ops in flight -> next cycle out_valid=0, ovf=unf=0, in_ready=1; no stale result ever emerges.

Source files
------------

// File: rtl/fp_mul_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// valid/ready: a transfer happens on a clk edge where valid & ready are both 1; a producer holding valid keeps its payload stable until that edge.
interface fp_mul_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         ovf;
    logic         unf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, ovf, unf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, ovf, unf
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier: decode/classify, mantissa multiply, normalise/round/pack.
// One global advance enable stalls every stage together when the output is blocked.
module fp_mul_pipe #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int ROUND_MODE = 1
) (
    input  logic      clk,
    input  logic      rst,
    fp_mul_if.slave   bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 2;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EZERO = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;

    // S1 registers
    logic                  s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
    logic signed [EW-1:0]  s1_e;
    logic [MAN_W:0]        s1_ma, s1_mb;
    // S2 registers
    logic                  s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
    logic signed [EW-1:0]  s2_e;
    logic [PW-1:0]         s2_p;
    // S3 registers
    logic                  s3_valid, s3_ovf, s3_unf;
    logic [W-1:0]          s3_out;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    assign adv          = ~s3_valid | bus.out_ready;
    assign bus.in_ready = adv;

    assign a_exp  = bus.a[MAN_W +: EXP_W];
    assign b_exp  = bus.b[MAN_W +: EXP_W];
    assign a_man  = bus.a[MAN_W-1:0];
    assign b_man  = bus.b[MAN_W-1:0];
    // Denormals have a zero exponent and are treated as zero.
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (&a_exp) & (a_man == '0);
    assign b_inf  = (&b_exp) & (b_man == '0);
    assign a_nan  = (&a_exp) & (|a_man);
    assign b_nan  = (&b_exp) & (|b_man);

    logic [MAN_W-1:0]     mant;
    logic                 guard, sticky, round_up;
    logic [MAN_W:0]       mant_r;
    logic signed [EW-1:0] e_n;
    logic [W-1:0]         res_out;
    logic                 res_ovf, res_unf;

    always_comb begin
        mant     = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        round_up = 1'b0;
        mant_r   = '0;
        e_n      = s2_e;
        res_out  = '0;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;

        if (s2_p[PW-1]) begin
            mant   = s2_p[PW-2 -: MAN_W];
            guard  = s2_p[MAN_W];
            sticky = |s2_p[MAN_W-1:0];
            e_n    = s2_e + EW'(1);
        end else begin
            mant   = s2_p[PW-3 -: MAN_W];
            guard  = s2_p[MAN_W-1];
            sticky = |s2_p[MAN_W-2:0];
        end

        round_up = (ROUND_MODE == 1) & guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + (MAN_W+1)'(round_up);
        // A carry out of the rounded mantissa lands exactly on the next power of two.
        if (mant_r[MAN_W]) begin
            e_n = e_n + EW'(1);
        end

        if (s2_nan) begin
            res_out = QNAN;
        end else if (s2_inf) begin
            res_out = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s2_zero) begin
            res_out = '0;
        end else if (e_n >= EMAX) begin
            res_out = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_ovf = 1'b1;
        end else if (e_n <= EZERO) begin
            res_out = '0;
            res_unf = 1'b1;
        end else begin
            res_out = {s2_sign, e_n[EXP_W-1:0], mant_r[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0; s1_sign <= 1'b0; s1_nan <= 1'b0; s1_inf <= 1'b0; s1_zero <= 1'b0;
            s1_e     <= '0;   s1_ma   <= '0;   s1_mb  <= '0;
            s2_valid <= 1'b0; s2_sign <= 1'b0; s2_nan <= 1'b0; s2_inf <= 1'b0; s2_zero <= 1'b0;
            s2_e     <= '0;   s2_p    <= '0;
            s3_valid <= 1'b0; s3_out  <= '0;   s3_ovf <= 1'b0; s3_unf <= 1'b0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_sign  <= bus.a[W-1] ^ bus.b[W-1];
            s1_nan   <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
            s1_inf   <= a_inf | b_inf;
            s1_zero  <= a_zero | b_zero;
            s1_e     <= EW'(a_exp) + EW'(b_exp) - EW'(BIAS);
            s1_ma    <= {1'b1, a_man};
            s1_mb    <= {1'b1, b_man};

            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_nan   <= s1_nan;
            s2_inf   <= s1_inf;
            s2_zero  <= s1_zero;
            s2_e     <= s1_e;
            s2_p     <= s1_ma * s1_mb;

            s3_valid <= s2_valid;
            // An emptying S3 also clears its payload and flags.
            s3_out   <= s2_valid ? res_out : '0;
            s3_ovf   <= s2_valid & res_ovf;
            s3_unf   <= s2_valid & res_unf;
        end
    end

    assign bus.out_valid = s3_valid;
    assign bus.out       = s3_out;
    assign bus.ovf       = s3_ovf;
    assign bus.unf       = s3_unf;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe: drivers push expected {ovf,unf,out} into queues, monitors pop and compare.
module tb_fp_mul_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;

    // ---------------- clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fp_mul_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
    fp_mul_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus_t ();

    fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .ROUND_MODE(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .ROUND_MODE(0)) dut_t (
        .clk(clk), .rst(rst), .bus(bus_t)
    );

    // ---------------- scoreboard state
    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] exp_t_q[$];
    int           acc_q[$];
    bit           lat_chk = 1'b0;
    bit           stalled = 1'b0;
    logic [W+1:0] held;

    // ---------------- monitors (sample 2 time units after the falling edge)
    always @(negedge clk) begin
        logic [W+1:0] e;
        logic [W+1:0] got;
        int           acc;
        #2;
        got = {bus.ovf, bus.unf, bus.out};
        if (!rst) begin
            if (stalled && bus.out_valid) begin
                checks++;
                if (got !== held) begin
                    errors++;
                    $display("FAIL stall_hold got=%h want=%h", got, held);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result got=%h at cycle %0d", got, cyc);
                end else begin
                    e   = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL result got {ovf,unf,out}=%h want=%h", got, e);
                    end
                    if (lat_chk) begin
                        checks++;
                        if (cyc - acc != 3) begin
                            errors++;
                            $display("FAIL latency got=%0d want=3", cyc - acc);
                        end
                    end
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = got;
        end else begin
            stalled = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [W+1:0] got;
        #2;
        got = {bus_t.ovf, bus_t.unf, bus_t.out};
        if (!rst && bus_t.out_valid) begin
            checks++;
            if (exp_t_q.size() == 0) begin
                errors++;
                $display("FAIL trunc_unexpected got=%h", got);
            end else if (got !== exp_t_q[0]) begin
                errors++;
                $display("FAIL trunc_result got=%h want=%h", got, exp_t_q[0]);
                void'(exp_t_q.pop_front());
            end else begin
                void'(exp_t_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks (called at a falling edge)
    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W+1:0] e, input bit push);
        int t = 0;
        bus.a        = xa;
        bus.b        = xb;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b want=1", bus.in_ready);
        end else if (push) begin
            exp_q.push_back(e);
            acc_q.push_back(cyc);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || exp_t_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_t_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d want=0", name, exp_q.size() + exp_t_q.size());
        end
    endtask

    // ---------------- directed vectors: a, b, expected {ovf,unf,out}
    logic [W-1:0] va [16];
    logic [W-1:0] vb [16];
    logic [W+1:0] ve [16];
    logic [W-1:0] bp_a [8];
    logic [W-1:0] bp_e [8];

    initial begin
        bit saw_low;

        va = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h7F000000,
               32'h00800000, 32'h7F800000, 32'h80000000, 32'hC0000000,
               32'hFF800000, 32'h7FC12345, 32'h00800000, 32'h00800000,
               32'h7F000000, 32'h7F000000, 32'h00400000, 32'hFF800000};
        vb = '{32'h40400000, 32'h3FC00000, 32'h3FC00000, 32'h7F000000,
               32'h00800000, 32'h00000000, 32'h40000000, 32'h40400000,
               32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F000000,
               32'h40000000, 32'h3F800000, 32'h40000000, 32'h80000000};
        ve = '{{2'b00, 32'h40C00000}, {2'b00, 32'h40100000}, {2'b00, 32'h3FC00002}, {2'b10, 32'h7F800000},
               {2'b01, 32'h00000000}, {2'b00, 32'h7FC00000}, {2'b00, 32'h00000000}, {2'b00, 32'hC0C00000},
               {2'b00, 32'hFF800000}, {2'b00, 32'h7FC00000}, {2'b00, 32'h00800000}, {2'b01, 32'h00000000},
               {2'b10, 32'h7F800000}, {2'b00, 32'h7F000000}, {2'b00, 32'h00000000}, {2'b00, 32'h7FC00000}};
        // 1.0..8.0 times 2.0
        bp_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        bp_e = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                 32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.out_ready   = 1'b1;
        bus_t.in_valid  = 1'b0;
        bus_t.a         = '0;
        bus_t.b         = '0;
        bus_t.out_ready = 1'b1;

        // ---- reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if ({bus.out_valid, bus.ovf, bus.unf, bus.in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_state got {ov,ovf,unf,ir}=%b want=0001",
                     {bus.out_valid, bus.ovf, bus.unf, bus.in_ready});
        end
        @(negedge clk);

        // ---- directed, back-to-back, full throughput
        lat_chk = 1'b1;
        for (int i = 0; i < 16; i++) send(va[i], vb[i], ve[i], 1'b1);
        drain("directed");
        lat_chk = 1'b0;

        // ---- truncation instance: the rounding tie keeps the low mantissa
        bus_t.a        = 32'h3F800001;
        bus_t.b        = 32'h3FC00000;
        bus_t.in_valid = 1'b1;
        exp_t_q.push_back({2'b00, 32'h3FC00001});
        @(negedge clk);
        bus_t.in_valid = 1'b0;
        drain("trunc");

        // ---- backpressure mid-stream
        saw_low = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(bp_a[i], 32'h40000000, {2'b00, bp_e[i]}, 1'b1);
            end
            begin
                repeat (4) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (5) begin
                    #1;
                    if (!bus.in_ready) saw_low = 1'b1;
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        checks++;
        if (!saw_low) begin
            errors++;
            $display("FAIL bp_in_ready_drop got=1 want=0 while stalled");
        end
        drain("backpressure");

        // ---- reset with three operations in flight
        bus.out_ready = 1'b0;
        send(32'h40000000, 32'h40400000, '0, 1'b0);
        send(32'h3FC00000, 32'h3FC00000, '0, 1'b0);
        send(32'h40400000, 32'h40400000, '0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        checks++;
        if ({bus.out_valid, bus.ovf, bus.unf, bus.in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_state got {ov,ovf,unf,ir}=%b want=0001",
                     {bus.out_valid, bus.ovf, bus.unf, bus.in_ready});
        end
        // Any stale result now would reach the monitor with an empty queue.
        repeat (8) @(negedge clk);

        // ---- one more op after the mid-flight reset
        send(32'h40400000, 32'h40400000, {2'b00, 32'h41100000}, 1'b1);
        drain("post_reset");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
